// File: rtl/multi_4bits.sv
// Unsigned bits x bits shift-and-add multiplier; any operand change restarts the computation.
// Define MULTI_4BITS_VALID_EN to add valid_o, high when Product_o matches the present operands.
module multi_4bits #(
  parameter int bits = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [bits-1:0]   A,
  input  logic [bits-1:0]   B,
  output logic [2*bits-1:0] Product_o
`ifdef MULTI_4BITS_VALID_EN
  ,
  output logic              valid_o
`endif
);

  localparam int CW = (bits > 1) ? $clog2(bits) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t              state, state_nxt;
  logic [bits-1:0]     a_q, a_nxt;
  logic [bits-1:0]     b_q, b_nxt;
  logic [2*bits-1:0]   acc, acc_nxt;
  logic [2*bits-1:0]   prod_nxt;
  logic [2*bits-1:0]   addend;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                changed;

  assign changed = ({A, B} != {a_q, b_q});
  assign addend  = {{bits{1'b0}}, a_q} << cnt;

`ifdef MULTI_4BITS_VALID_EN
  assign valid_o = (state == IDLE) && !changed;
`endif

  // Any operand change recaptures and restarts; Product_o moves only on a clean DONE.
  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    b_nxt     = b_q;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    prod_nxt  = Product_o;
    if (changed) begin
      a_nxt     = A;
      b_nxt     = B;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      state_nxt = CALC;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        CALC: begin
          if (b_q[cnt]) acc_nxt = acc + addend;
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(bits - 1)) state_nxt = DONE;
        end
        DONE: begin
          prod_nxt  = acc;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      Product_o <= '0;
    end else begin
      state     <= state_nxt;
      a_q       <= a_nxt;
      b_q       <= b_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      Product_o <= prod_nxt;
    end
  end

endmodule

// File: tb/tb_multi_4bits.sv
// Self-checking bench for multi_4bits: directed cases, exhaustive sweep and random operand changes
// against a latency-level reference model.
module tb_multi_4bits;

  localparam int bits = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] A = 4'd9;
  logic [3:0] B = 4'd9;
  logic [7:0] Product_o;
`ifdef MULTI_4BITS_VALID_EN
  logic       valid_o;
`endif

  multi_4bits #(.bits(bits)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .Product_o (Product_o)
`ifdef MULTI_4BITS_VALID_EN
    ,
    .valid_o   (valid_o)
`endif
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference: the product of a stable operand pair appears bits+1 edges after it is first seen.
  int  expProd   = 0;
  int  lastA     = 0;
  int  lastB     = 0;
  int  countdown = 0;
  bit  modelLive = 0;
  bit  watch63   = 0;
  bit  seen63    = 0;

  always @(posedge clk) begin
    if (!rst) begin
      expProd   = 0;
      lastA     = 0;
      lastB     = 0;
      countdown = 0;
      modelLive = 1;
    end else if (int'(A) != lastA || int'(B) != lastB) begin
      lastA     = int'(A);
      lastB     = int'(B);
      countdown = bits + 1;
    end else if (countdown > 0) begin
      countdown--;
      if (countdown == 0) expProd = lastA * lastB;
    end
  end

  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("cycle", {8'd0, Product_o}, 16'(expProd));
`ifdef MULTI_4BITS_VALID_EN
      if (rst)
        checkOutput("valid", {15'd0, valid_o},
                    {15'd0, (countdown == 0 && int'(A) == lastA && int'(B) == lastB)});
`endif
    end
    if (watch63 && Product_o == 8'd63) seen63 = 1;
  end

  task automatic applyStimulus(input int a, input int b, input int cycles);
    @(negedge clk);
    #1;
    A = 4'(a);
    B = 4'(b);
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_hold", {8'd0, Product_o}, 16'd0);
    rst = 1'b1;

    applyStimulus(3, 5, 6);
    checkOutput("p3x5", {8'd0, Product_o}, 16'd15);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("p3x5_stable", {8'd0, Product_o}, 16'd15);

    applyStimulus(15, 15, 6);
    checkOutput("p15x15", {8'd0, Product_o}, 16'd225);
    applyStimulus(0, 13, 6);
    checkOutput("p0x13", {8'd0, Product_o}, 16'd0);
    applyStimulus(1, 1, 6);
    checkOutput("p1x1", {8'd0, Product_o}, 16'd1);

    watch63 = 1;
    applyStimulus(7, 9, 2);
    applyStimulus(2, 3, 6);
    watch63 = 0;
    checkOutput("restart_result", {8'd0, Product_o}, 16'd6);
    checkOutput("no_stale_63", {15'd0, seen63}, 16'd0);

    applyStimulus(12, 11, 2);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("midcalc_reset", {8'd0, Product_o}, 16'd0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("after_reset_12x11", {8'd0, Product_o}, 16'd132);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(a, b, 10);
        checkOutput("sweep", {8'd0, Product_o}, 16'(a * b));
      end
    end

    for (int i = 0; i < 200; i++) begin
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(1, 8)));
    end
    applyStimulus(int'(A), int'(B), 6);
    checkOutput("random_final", {8'd0, Product_o}, 16'(int'(A) * int'(B)));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
